state_dump_unit: RTL

Hardware state-dump engine that sits beside the CPU core and serialises architectural state out over a valid/ready stream. On a start pulse it freezes the core through `halt_o`, then reads every register-file entry followed by every data-memory word through dedicated read ports. Each word is emitted as a tagged beat, and the engine pulses `done_o` when the dump is complete. It is the producer end of the state-inspection path, giving a non-hierarchical route to the same register and memory contents.

---
 rtl/state_dump_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/state_dump_unit.sv
// State-dump engine: freezes the core, then streams every register-file entry
// followed by every data-memory word as tagged valid/ready beats.
module state_dump_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_COUNT = 32,
  parameter int IDX_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              halt_o,
  output logic              done_o,
  output logic [IDX_W-1:0]  reg_raddr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic [IDX_W-1:0]  mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic              dump_sel_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_SEND, S_DONE} state_t;

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_COUNT - 1);

  state_t              r_state;
  logic                r_sel;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_halt;
  logic                r_done;
  logic                r_valid;
  logic                r_dsel;
  logic [IDX_W-1:0]    r_didx;
  logic [DATA_W-1:0]   r_ddata;

  // Read ports follow the cursor directly; the cursor only moves on a handshake,
  // so the addressed data has a full RD cycle to settle.
  assign reg_raddr_o  = r_idx;
  assign mem_raddr_o  = r_idx;
  assign busy_o       = r_busy;
  assign halt_o       = r_halt;
  assign done_o       = r_done;
  assign dump_valid_o = r_valid;
  assign dump_sel_o   = r_dsel;
  assign dump_idx_o   = r_didx;
  assign dump_data_o  = r_ddata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_halt  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_dsel  <= 1'b0;
      r_didx  <= '0;
      r_ddata <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_WAIT;
            r_sel   <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_halt  <= 1'b1;
          end
        end
        S_WAIT: r_state <= S_RD;
        S_RD: begin
          r_ddata <= r_sel ? mem_rdata_i : reg_rdata_i;
          r_dsel  <= r_sel;
          r_didx  <= r_idx;
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (dump_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_RD;
            if (!r_sel) begin
              if (r_idx == REG_LAST) begin
                r_sel <= 1'b1;
                r_idx <= '0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else if (r_idx == MEM_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_halt  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
